// File: rtl/lfsr_range_rng_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_range_rng_if
// Brief    : Control/draw bundle between the game controller and lfsr_range_rng.
// Revision : 1.0 - initial release
// ============================================================================
interface lfsr_range_rng_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 4
);
    logic             i_en;
    logic             i_load;
    logic [WIDTH-1:0] i_seed;
    logic             i_req;
    logic [OUT_W-1:0] i_range;
    logic [WIDTH-1:0] o_q;
    logic [OUT_W-1:0] o_rnd;
    logic             o_valid;
    logic             o_busy;

    modport slave (
        input  i_en, i_load, i_seed, i_req, i_range,
        output o_q, o_rnd, o_valid, o_busy
    );

    modport master (
        output i_en, i_load, i_seed, i_req, i_range,
        input  o_q, o_rnd, o_valid, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_range_rng.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_range_rng
// Brief    : Galois LFSR with seed load and a mask-and-reject bounded draw.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_range_rng #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(16'h002D),
    parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
    parameter int               OUT_W     = 4,
    parameter int               MAX_TRIES = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    lfsr_range_rng_if.slave   bus
);
    localparam int               TRY_W      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] c_TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_DRAW     = 1'b1;

    logic [WIDTH-1:0] r_q;
    logic [OUT_W-1:0] r_rnd;
    logic [OUT_W-1:0] r_range;
    logic [OUT_W-1:0] r_mask;
    logic             r_valid;
    logic [0:0]       r_state;
    logic [TRY_W-1:0] r_try;

    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_seed_eff;
    logic [OUT_W-1:0] w_range_m1;
    logic [OUT_W-1:0] w_mask;
    logic [OUT_W-1:0] w_cand;
    logic             w_accept;

    always_comb begin
        w_q_step   = {r_q[WIDTH-2:0], 1'b0} ^ (r_q[WIDTH-1] ? POLY : '0);
        w_seed_eff = (bus.i_seed == '0) ? SEED : bus.i_seed;
        // Smearing Range-1 rightwards gives the smallest 2^k-1 covering it;
        // Range=0 wraps to all ones, i.e. the full output range.
        w_range_m1 = bus.i_range - OUT_W'(1);
        w_mask     = w_range_m1;
        for (int i = 1; i < OUT_W; i++) begin
            w_mask = w_mask | (w_range_m1 >> i);
        end
        w_cand   = r_q[OUT_W-1:0] & r_mask;
        w_accept = (r_range == '0) || (w_cand < r_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= SEED;
            r_rnd   <= '0;
            r_range <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
            r_state <= c_IDLE;
            r_try   <= '0;
        end else if (bus.i_load) begin
            r_q     <= w_seed_eff;
            r_valid <= 1'b0;
            r_state <= c_IDLE;
            r_try   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.i_en) begin
                        r_q <= w_q_step;
                    end
                    if (bus.i_req) begin
                        r_range <= bus.i_range;
                        r_mask  <= w_mask;
                        r_try   <= '0;
                        r_state <= c_DRAW;
                    end
                end
                c_DRAW: begin
                    r_q <= w_q_step;
                    if (w_accept) begin
                        r_rnd   <= w_cand;
                        r_valid <= 1'b1;
                        r_state <= c_IDLE;
                    end else if (r_try == c_TRY_LAST) begin
                        // mask <= 2*Range-1, so halving always lands in range
                        r_rnd   <= w_cand >> 1;
                        r_valid <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_try <= r_try + TRY_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.o_q     = r_q;
    assign bus.o_rnd   = r_rnd;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = (r_state == c_DRAW);
endmodule
`default_nettype wire

// File: tb/tb_lfsr_range_rng.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_range_rng
// Brief    : Self-checking bench: whole-draw outcome model plus literal pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_range_rng;
    localparam int MT = 8;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 0;

    lfsr_range_rng_if #(.WIDTH(16), .OUT_W(4)) m  ();
    lfsr_range_rng_if #(.WIDTH(16), .OUT_W(4)) m1 ();

    lfsr_range_rng #(.MAX_TRIES(MT)) u_dut  (.clk(clk), .rst(rst), .bus(m.slave));
    lfsr_range_rng #(.MAX_TRIES(1))  u_dut1 (.clk(clk), .rst(rst), .bus(m1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int q);
        return ((q * 2) % 65536) ^ ((q >= 32768) ? 16'h002D : 0);
    endfunction

    // Predicts the whole draw at request time: how many DRAW edges and the result.
    task automatic plan(input int q0, input int rng, output int left, output int res);
        int p;
        int mask;
        int q;
        int c;
        p = 1;
        while (p < rng) p = p * 2;
        mask = (rng == 0) ? 15 : p - 1;
        q = q0;
        left = MT;
        res = 0;
        for (int t = 0; t < MT; t++) begin
            c = (q % 16) & mask;
            if (rng == 0 || c < rng) begin
                res = c; left = t + 1; return;
            end
            if (t == MT - 1) begin
                res = c / 2; left = MT; return;
            end
            q = lfsr_next(q);
        end
    endtask

    int m_q, m_rnd, m_left, m_res, m_rng;
    bit m_valid, m_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_q = 16'hFFFF; m_rnd = 0; m_valid = 0; m_busy = 0;
        end else if (m.i_load) begin
            m_q = (m.i_seed == 0) ? 16'hFFFF : int'(m.i_seed);
            m_valid = 0; m_busy = 0;
        end else if (!m_busy) begin
            m_valid = 0;
            if (m.i_en) m_q = lfsr_next(m_q);
            if (m.i_req) begin
                m_rng = int'(m.i_range);
                plan(m_q, m_rng, m_left, m_res);
                m_busy = 1;
            end
        end else begin
            m_q = lfsr_next(m_q);
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_valid = 1; m_rnd = m_res;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("q",       32'(m.o_q),     32'(m_q));
            check("rnd",     32'(m.o_rnd),   32'(m_rnd));
            check("valid",   32'(m.o_valid), 32'(m_valid));
            check("busy",    32'(m.o_busy),  32'(m_busy));
            check("q_nonzero", 32'(m.o_q != 0), 32'd1);
            if (m.o_valid && m_rng != 0)
                check("rnd_in_range", 32'(int'(m.o_rnd) < m_rng), 32'd1);
        end
    end

    initial begin
        rst = 1;
        m.i_en = 0;  m.i_load = 0;  m.i_seed = 0;  m.i_req = 0;  m.i_range = 0;
        m1.i_en = 0; m1.i_load = 0; m1.i_seed = 0; m1.i_req = 0; m1.i_range = 0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 0;
        check("rst_q", 32'(m.o_q), 32'hFFFF);
        check("rst_rnd", 32'(m.o_rnd), 32'h0);
        check("rst_busy", 32'(m.o_busy), 32'h0);

        m.i_en = 1;
        @(negedge clk); check("step1", 32'(m.o_q), 32'hFFD3);
        @(negedge clk); check("step2", 32'(m.o_q), 32'hFF8B);
        m.i_en = 0;

        m.i_load = 1; m.i_seed = 16'h0000;
        @(negedge clk); check("load_zero", 32'(m.o_q), 32'hFFFF);
        m.i_seed = 16'h1234;
        @(negedge clk); check("load_1234", 32'(m.o_q), 32'h1234);
        m.i_load = 0;

        rst = 1; @(negedge clk); rst = 0;
        m.i_req = 1; m.i_range = 4'd0;
        @(negedge clk); m.i_req = 0;
        check("r0_busy", 32'(m.o_busy), 32'h1);
        @(negedge clk);
        check("r0_valid", 32'(m.o_valid), 32'h1);
        check("r0_rnd", 32'(m.o_rnd), 32'hF);
        check("r0_q", 32'(m.o_q), 32'hFFD3);
        @(negedge clk);
        check("r0_pulse", 32'(m.o_valid), 32'h0);

        rst = 1; @(negedge clk); rst = 0;
        m.i_req = 1; m.i_range = 4'd5;
        @(negedge clk); m.i_req = 0;
        @(negedge clk);
        check("r5_reject", 32'(m.o_valid), 32'h0);
        check("r5_busy", 32'(m.o_busy), 32'h1);
        @(negedge clk);
        check("r5_valid", 32'(m.o_valid), 32'h1);
        check("r5_rnd", 32'(m.o_rnd), 32'h3);

        m.i_req = 1; m.i_range = 4'd5;
        @(negedge clk); m.i_req = 0;
        check("abort_busy0", 32'(m.o_busy), 32'h1);
        m.i_load = 1; m.i_seed = 16'hABCD;
        @(negedge clk); m.i_load = 0;
        check("abort_busy", 32'(m.o_busy), 32'h0);
        check("abort_valid", 32'(m.o_valid), 32'h0);
        check("abort_rnd", 32'(m.o_rnd), 32'h3);
        check("abort_q", 32'(m.o_q), 32'hABCD);

        rst = 1; @(negedge clk); rst = 0;
        m1.i_req = 1; m1.i_range = 4'd5;
        @(negedge clk); m1.i_req = 0;
        check("mt1_busy", 32'(m1.o_busy), 32'h1);
        @(negedge clk);
        check("mt1_valid", 32'(m1.o_valid), 32'h1);
        check("mt1_fallback", 32'(m1.o_rnd), 32'h3);
        m1.i_req = 1; m1.i_range = 4'd1;
        @(negedge clk); m1.i_req = 0;
        @(negedge clk);
        check("mt1_r1_valid", 32'(m1.o_valid), 32'h1);
        check("mt1_r1_rnd", 32'(m1.o_rnd), 32'h0);

        for (int c = 0; c < 50000; c++) begin
            @(negedge clk);
            m.i_en    = 1'($urandom_range(0, 1));
            m.i_req   = ($urandom_range(0, 3) != 0);
            m.i_range = ($urandom_range(0, 19) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            m.i_load  = ($urandom_range(0, 299) == 0);
            m.i_seed  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        end
        @(negedge clk);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lfsr_range_rng.md
Name: lfsr_range_rng

Overview:
- Parametrised Galois LFSR pseudo-random generator with run-time seed load and a bounded-range draw engine.
- Serves game-sequence generation: the LFSR free-runs when enabled.
- A Req/Valid handshake returns an unbiased value in [0, Range-1] using mask-and-reject sampling, with a bounded retry count.
- Sits beside the game controller and replaces fixed 16-bit LFSR instances.

Parameters:
- WIDTH, 16, LFSR register width (>= OUT_W, >= 2).
- POLY, 16'h002D, Galois tap mask, WIDTH bits; bit0 must be 1; bit i set means the feedback is XORed into bit i.
- SEED, all ones (WIDTH bits), reset value; also substituted for any all-zero load.
- OUT_W, 4, width of Range and Rnd.
- MAX_TRIES, 8, maximum candidates evaluated per draw (>= 1).

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous reset, active-high.
- En  in  1  advance the LFSR one step per cycle while IDLE.
- Load  in  1  load Seed into LFSR this edge.
- Seed  in  WIDTH  seed value for Load.
- Req  in  1  draw request, sampled only in IDLE.
- Range  in  OUT_W  exclusive upper bound; 0 means full range 2^OUT_W.
- Q  out  WIDTH  current LFSR state.
- Rnd  out  OUT_W  last drawn value, held until the next Valid.
- Valid  out  1  one-cycle pulse: Rnd updated.
- Busy  out  1  draw in progress (state DRAW).

Behaviour:
- Reset (Rst=1 at an edge):
  - Q=SEED, Rnd=0, Valid=0, Busy=0, state IDLE, try counter=0.
  - Reset overrides all other inputs.
- LFSR step (Galois, shift toward MSB):
  - fb = Q[WIDTH-1].
  - next = {Q[WIDTH-2:0],1'b0} XOR (fb ? POLY : 0).
  - With POLY=16'h002D this equals bit0=fb; bits 2,3,5 = shifted bit XOR fb; all others pure shift.
- Priority per edge: Rst > Load > FSM activity.
- Load:
  - Q = (Seed==0) ? SEED : Seed. The all-zero lock-up state can never be entered.
  - Load aborts any draw: state to IDLE, Busy=0, no Valid pulse, Rnd unchanged.
  - A Req coincident with Load is dropped.
- State IDLE:
  - Q advances iff En=1.
  - Req=1 latches Range into an internal range register and the try counter clears to 0.
  - Mask is latched as the smallest 2^k-1 >= Range-1, i.e. all ones when Range=0 and 0 when Range=1.
  - Next state DRAW, Busy=1.
  - Req is ignored while Busy=1.
- State DRAW, every edge:
  - cand = Q[OUT_W-1:0] & mask, evaluated on the pre-edge Q.
  - Q advances every DRAW edge regardless of En.
  - Accept if Range=0, or cand < Range: Rnd=cand, Valid=1 for one cycle, state IDLE, Busy=0.
  - Else, if try counter == MAX_TRIES-1: fallback Rnd=cand>>1, which is always < Range because mask <= 2*Range-1. Valid=1, state IDLE.
  - Else the try counter increments and the state stays DRAW.
- Latency: Req edge e0 puts Busy high. Valid appears after e1 at minimum and after e(MAX_TRIES) at maximum. A new Req can be accepted on the edge after Valid.
- Valid is never asserted in IDLE except on the cycle immediately after the completing edge. Back-to-back draws are therefore separated by at least one IDLE cycle.
- Range changes while DRAW have no effect, because the latched value is used.

Test Plan:
- Reset, En=1 for 1 cycle -> Q: 0xFFFF then 0xFFD3. Second step: fb=1 gives 0xFFA6^0x002D = 0xFF8B.
- Load=1, Seed=0 -> Q=0xFFFF. Load, Seed=0x1234 -> Q=0x1234. Load asserted mid-DRAW -> Busy=0 next cycle, no Valid, Rnd unchanged.
- After reset, En=0, Req with Range=0 -> Busy=1 after e0; after e1 Valid=1, Rnd=15, Q=0xFFD3.
- After reset, Req with Range=5 (mask 7) -> first cand 7 is rejected; second cand from 0xFFD3 is 3 and accepted. Valid after e2, Rnd=3.
- MAX_TRIES=1, Range=5, Q=0xFFFF -> fallback Rnd=3 (7>>1), Valid after e1. Range=1 -> Rnd=0 after e1.
- Random soak, 10k draws, Range 1..15 -> every Rnd < Range; Valid is exactly one cycle per Req; Req while Busy is ignored; Q is never 0.
